// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM encoding and
// address-width helper.
package regfile_dump_reader_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StSend = 2'd2,
        StFin  = 2'd3
    } dump_state_e;

    // Never returns 0 so a single-entry file still gets a 1-bit address.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_out_reg.sv
// SEND holding register: captures one word and keeps it stable until the
// downstream handshake or an abort retires it.
module regfile_dump_reader_out_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_capture,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic [AW-1:0]    i_addr,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [AW-1:0]    o_addr,
    output logic             o_last
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [AW-1:0]    r_addr;
    logic             r_last;
    logic             w_valid_next;

    always_comb begin
        w_valid_next = r_valid;
        if (i_flush) begin
            w_valid_next = 1'b0;
        end else if (i_capture) begin
            w_valid_next = 1'b1;
        end else if (r_valid && i_ready) begin
            w_valid_next = 1'b0;
        end
    end

    // Payload only loads on capture, so it cannot move while stalled in SEND.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= w_valid_next;
            if (i_capture) begin
                r_data <= i_data;
                r_addr <= i_addr;
                r_last <= i_last;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_addr  = r_addr;
    assign o_last  = r_last;

endmodule

// File: rtl/regfile_dump_reader.sv
// Sequential debug reader: walks a register-file address range on a spare
// asynchronous read port and streams each word over valid/ready.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW   = addr_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [AW-1:0]    i_first_addr,
    input  logic [AW-1:0]    i_last_addr,
    input  logic             i_abort,
    output logic [AW-1:0]    o_rf_read_addr,
    input  logic [WIDTH-1:0] i_rf_read_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [AW-1:0]    o_out_addr,
    output logic             o_out_last,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    dump_state_e   r_state;
    dump_state_e   w_state_next;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_next;
    logic [AW-1:0] r_end_ptr;
    logic [AW-1:0] w_end_ptr_next;
    logic [AW-1:0] w_ptr_inc;
    logic          w_capture;
    logic          w_is_last;

    // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
    assign w_ptr_inc = (r_ptr == LastIdx) ? '0 : r_ptr + AW'(1);
    assign w_is_last = (r_ptr == r_end_ptr);

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_end_ptr_next = r_end_ptr;
        w_capture      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start && !i_abort) begin
                    w_state_next   = StRead;
                    w_ptr_next     = i_first_addr;
                    w_end_ptr_next = i_last_addr;
                end
            end
            StRead: begin
                if (i_abort) begin
                    w_state_next = StIdle;
                end else begin
                    w_capture    = 1'b1;
                    w_state_next = StSend;
                end
            end
            StSend: begin
                // Abort beats a same-cycle handshake; that word is dropped.
                if (i_abort) begin
                    w_state_next = StIdle;
                end else if (i_out_ready) begin
                    if (o_out_last) begin
                        w_state_next = StFin;
                    end else begin
                        w_ptr_next   = w_ptr_inc;
                        w_state_next = StRead;
                    end
                end
            end
            StFin: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_ptr     <= '0;
            r_end_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_end_ptr <= w_end_ptr_next;
        end
    end

    regfile_dump_reader_out_reg #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_out_reg (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_capture (w_capture),
        .i_flush   (i_abort),
        .i_data    (i_rf_read_data),
        .i_addr    (r_ptr),
        .i_last    (w_is_last),
        .i_ready   (i_out_ready),
        .o_valid   (o_out_valid),
        .o_data    (o_out_data),
        .o_addr    (o_out_addr),
        .o_last    (o_out_last)
    );

    assign o_rf_read_addr = r_ptr;
    assign o_busy         = (r_state != StIdle);
    // An abort landing in FIN suppresses the completion pulse.
    assign o_done         = (r_state == StFin) && !i_abort;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a register-file model and an
// expected-word queue filled at start and drained on each handshake.
module tb_regfile_dump_reader;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AW-1:0]    first_addr;
    logic [AW-1:0]    last_addr;
    logic             abort;
    logic [AW-1:0]    rf_read_addr;
    logic [WIDTH-1:0] rf_read_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [AW-1:0]    out_addr;
    logic             out_last;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] rf [DEPTH];

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             last;
    } word_t;

    word_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    assign rf_read_data = rf[rf_read_addr];

    regfile_dump_reader #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_first_addr   (first_addr),
        .i_last_addr    (last_addr),
        .i_abort        (abort),
        .o_rf_read_addr (rf_read_addr),
        .i_rf_read_data (rf_read_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_data     (out_data),
        .o_out_addr     (out_addr),
        .o_out_last     (out_last),
        .o_busy         (busy),
        .o_done         (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
        int n;
        n = ((int'(l) - int'(f) + DEPTH) % DEPTH) + 1;
        for (int i = 0; i < n; i++) begin
            word_t         w;
            logic [AW-1:0] a;
            a      = AW'((int'(f) + i) % DEPTH);
            w.addr = a;
            w.data = rf[a];
            w.last = (i == n - 1);
            exp_q.push_back(w);
        end
    endtask

    // Called just after a falling edge; returns one cycle later with the DUT in READ.
    task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
        push_range(f, l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // stall: cycles of out_ready=0 on the first word; inject: cycle of a stray start.
    task automatic drain(input int stall, input int inject, input int budget);
        int    cyc        = 1;
        int    prev_hs    = -1;
        int    first_vcyc = 0;
        int    stall_left = stall;
        bit    got_last   = 1'b0;
        word_t w;
        while (!got_last && cyc < budget) begin
            start = (cyc == inject);
            if (start) begin
                first_addr = 5'd9;
                last_addr  = 5'd9;
            end
            out_ready = (stall_left == 0);
            if (out_valid) begin
                if (prev_hs < 0) begin
                    first_vcyc++;
                    if (first_vcyc == 1) chk("first_valid_latency", cyc, 2);
                end
                chk("scoreboard_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    w = exp_q[0];
                    chk("word_addr", out_addr, w.addr);
                    chk("word_data", out_data, w.data);
                    chk("word_last", out_last, w.last);
                    if (out_ready) begin
                        w = exp_q.pop_front();
                        if (stall == 0 && prev_hs >= 0) chk("word_spacing", cyc - prev_hs, 2);
                        prev_hs  = cyc;
                        got_last = w.last;
                    end else begin
                        stall_left--;
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("dump_completed", got_last, 1);
        if (stall > 0) chk("valid_hold_cycles", first_vcyc, stall + 1);
        chk("done_pulse", done, 1);
        chk("busy_in_fin", busy, 1);
        chk("valid_in_fin", out_valid, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_fin", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t w;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        for (int i = 0; i < DEPTH; i++) rf[i] = $urandom;
        rf[0] = 32'h0BAD_F00D;
        rf[3] = 32'h0000_000A;
        rf[4] = 32'h0000_000B;
        rf[5] = 32'h0000_000C;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_rf_addr", rf_read_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic range with continuous ready.
        start_dump(5'd3, 5'd5);
        chk("busy_after_start", busy, 1);
        chk("rf_addr_in_read", rf_read_addr, 3);
        drain(0, 0, 20);

        // Wrap through DEPTH-1 to 0.
        start_dump(5'd30, 5'd1);
        drain(0, 0, 30);

        // Single word under backpressure.
        start_dump(5'd7, 5'd7);
        drain(5, 0, 30);

        // Stray start while busy must not disturb the range.
        out_ready = 1'b1;
        start_dump(5'd12, 5'd14);
        drain(0, 2, 30);

        // Abort on the third word's SEND cycle with ready high.
        out_ready = 1'b1;
        start_dump(5'd0, 5'd31);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("abort_pre_valid", out_valid, 1);
            w = exp_q.pop_front();
            chk("abort_pre_addr", out_addr, w.addr);
            chk("abort_pre_data", out_data, w.data);
            @(negedge clk);
        end
        @(negedge clk);
        chk("abort_word3_valid", out_valid, 1);
        chk("abort_word3_addr", out_addr, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid_drop", out_valid, 0);
        chk("abort_busy_drop", busy, 0);
        chk("abort_no_done", done, 0);
        @(negedge clk);
        chk("abort_no_done_later", done, 0);
        chk("abort_stays_idle", busy, 0);
        exp_q.delete();
        start_dump(5'd10, 5'd11);
        drain(0, 0, 20);

        // start and abort together in IDLE: abort wins.
        first_addr = 5'd2;
        last_addr  = 5'd2;
        start      = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_ptr", rf_read_addr, 11);
        @(negedge clk);
        chk("start_abort_valid", out_valid, 0);

        // Reset during READ; start held high alongside reset.
        start_dump(5'd4, 5'd6);
        reset      = 1'b1;
        start      = 1'b1;
        first_addr = 5'd9;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_last", out_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_addr", out_addr, 0);
        chk("midrst_rf_addr", rf_read_addr, 0);
        @(negedge clk);
        chk("midrst_start_ignored", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        chk("post_rst_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug read-out engine for the pipelined core's register file.
- On a start pulse, walks a contiguous address range over a spare register-file read port and captures each word.
- Streams each captured word on a valid/ready output interface to the debug/trace path.
- Pairs with the writeback-side writer: this block is the sequential reader of the same storage.

Parameters:
- WIDTH, 32, data width of one register.
- DEPTH, 32, number of registers; address width AW = $clog2(DEPTH).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- first_addr  input  AW  first register to dump; sampled with start.
- last_addr  input  AW  final register to dump; sampled with start.
- abort  input  1  cancel the dump in progress.
- rf_read_addr  output  AW  drives the register file's asynchronous read address port.
- rf_read_data  input  WIDTH  combinational read data returned for rf_read_addr.
- out_valid  output  1  out_data/out_addr/out_last are valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  captured register value.
- out_addr  output  AW  register index of out_data.
- out_last  output  1  marks the final word of the dump.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Interface decision: one clock `clk`. Reset `reset` is synchronous and active-high.
- Reset (synchronous, active-high, any state, including mid-dump):
  - state=IDLE; ptr, end_ptr=0.
  - out_valid, out_last, busy, done=0.
  - out_data, out_addr, rf_read_addr=0.
- States:
  - IDLE: waits for start.
  - READ: one cycle; rf_read_addr=ptr; rf_read_data is captured at the rising edge.
  - SEND: out_valid=1; holds until out_ready.
  - FIN: one cycle; done=1.
- Transitions:
  - IDLE & start: latch ptr=first_addr, end_ptr=last_addr; go to READ. busy=1 from the next cycle.
  - READ: at the edge, out_data<=rf_read_data, out_addr<=ptr, out_last<=(ptr==end_ptr); go to SEND.
  - SEND & out_ready & !out_last: ptr<=ptr+1, wrapping DEPTH-1 -> 0; go to READ.
  - SEND & out_ready & out_last: go to FIN.
  - FIN: go to IDLE; busy drops on the same edge.
- Throughput: at most one word per 2 cycles.
- Latency: start edge to first out_valid = 2 cycles.
- rf_read_addr holds ptr in all states, so it is stable during READ.
- In SEND, out_data, out_addr and out_last must not change while out_valid=1 and out_ready=0.
- Range rules:
  - first_addr==last_addr: exactly one word, with out_last=1.
  - first_addr>last_addr: the walk wraps through DEPTH-1 to 0 and ends at last_addr.
  - Words emitted = ((last-first) mod DEPTH)+1.
- Non-power-of-two DEPTH: the increment wraps explicitly at DEPTH-1, not by AW overflow.
- start while busy: ignored, no effect.
- start and abort in the same IDLE cycle: abort wins, stay IDLE.
- abort in READ/SEND/FIN:
  - Next state is IDLE; out_valid=0, busy=0 next cycle.
  - No done pulse; a word pending in SEND is dropped.
- abort has priority over an out_ready handshake in the same cycle; that word counts as not delivered.
- Coherency: each word reflects register contents at its own READ capture edge. Register writes that complete before that edge (writes land on the falling edge) are visible. The dump is not an atomic snapshot.
- out_data is held after the last handshake until overwritten or reset.

Decomposition:
- Shared core package: state encoding enum (IDLE, READ, SEND, FIN) and the AW computation function.
- Pointer-increment-with-wrap is small enough to stay inline; no sub-module required.
- Optional sub-module `dump_out_reg`: the SEND holding register with the valid/ready hold rule.

Test Plan:
- Range 3..5: preload R3=0xA, R4=0xB, R5=0xC; start, out_ready=1 constantly -> three words (3,0xA),(4,0xB),(5,0xC); out_last only on addr 5; done pulse one cycle after the third handshake; words spaced 2 cycles.
- Wrap: first=30, last=1, DEPTH=32 -> addresses 30,31,0,1 in order; R0 value emitted as stored; out_last on addr 1.
- Backpressure: range 7..7, out_ready=0 for 5 cycles then 1 -> out_valid held 6 cycles; out_data/out_addr stable throughout; single word with out_last=1.
- Abort mid-SEND: range 0..31, abort asserted on the 3rd word's SEND cycle with out_ready=1 -> only 2 words counted delivered; out_valid=0 and busy=0 next cycle; no done pulse; a new start is then accepted.
- Reset mid-dump: assert reset during READ -> next edge all outputs 0, state IDLE; start ignored while reset=1.
- start while busy: second start with first=9 during an active dump -> ignored; the original range completes unchanged.
